// File: rtl/hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hamming_secded_pipe
// Description : Two-stage pipelined Hamming SECDED encoder/decoder with
//               error injection and saturating error counters.
//
//               Stage 1 encodes in_data into an extended Hamming codeword and
//               XORs in inj_mask. Stage 2 decodes that codeword: it computes
//               the syndrome and overall parity, corrects single-bit errors,
//               flags double-bit errors and registers the results.
//
//               Codeword layout (CW_W = DATA_W + P + 1 bits):
//                 cw[0]          overall (even) parity over cw[CW_W-1:1]
//                 cw[2^k]        Hamming parity bit k
//                 other cw[i>0]  data bits in ascending order, in_data[0] first
//
// Ports       :
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   in_valid       in   input word present
//   in_ready       out  input accepted this cycle (= pipeline advance)
//   in_data        in   DATA_W  data to encode
//   inj_mask       in   CW_W    error-injection mask, sampled with in_data
//   out_valid      out  result present
//   out_ready      in   consumer accepts result
//   out_data       out  DATA_W  decoded (corrected or raw) data
//   out_cw         out  CW_W    codeword seen by the decoder
//   out_syndrome   out  P       Hamming syndrome
//   out_err_single out  single-bit error detected and corrected
//   out_err_double out  double-bit error detected, data left uncorrected
//   clr_cnt        in   synchronous clear of both counters
//   cnt_single     out  CNT_W   saturating single-error count
//   cnt_double     out  CNT_W   saturating double-error count
//
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_secded_pipe #(
    parameter int DATA_W = 4,
    parameter int P      = (DATA_W == 4) ? 3 : (DATA_W == 11) ? 4 : 5,
    parameter int CW_W   = DATA_W + P + 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CW_W-1:0]   inj_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW_W-1:0]   out_cw,
    output logic [P-1:0]      out_syndrome,
    output logic              out_err_single,
    output logic              out_err_double,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double
);

    // ------------------------------------------------------------------------
    // Configuration check: only the three perfect SECDED sizes are supported,
    // for which CW_W is exactly 2^P and every syndrome value is a valid index.
    // ------------------------------------------------------------------------
    localparam int P_EXPECTED = (DATA_W == 4) ? 3 : (DATA_W == 11) ? 4 : 5;

    generate
        if (!((DATA_W == 4) || (DATA_W == 11) || (DATA_W == 26)) ||
            (P != P_EXPECTED) || (CW_W != DATA_W + P + 1)) begin : g_cfg_err
            $error("hamming_secded_pipe: unsupported DATA_W/P/CW_W combination");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Codeword helpers
    // ------------------------------------------------------------------------

    // Data bits occupy every non-power-of-two position above 0.
    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        logic            par;
        int              di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[di];
                di      = di + 1;
            end
        end
        // Parity positions are still zero here, so including them in the
        // XOR is harmless and keeps the loop uniform.
        for (int k = 0; k < P; k++) begin
            par = 1'b0;
            for (int pos = 1; pos < CW_W; pos++) begin
                if (pos[k]) begin
                    par = par ^ cw[pos];
                end
            end
            cw[1 << k] = par;
        end
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int                di;
        d  = '0;
        di = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[di] = cw[pos];
                di    = di + 1;
            end
        end
        return d;
    endfunction

    function automatic logic [P-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
        logic [P-1:0] s;
        s = '0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (cw[pos]) begin
                s = s ^ pos[P-1:0];
            end
        end
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic              s1_valid_q,   s1_valid_d;
    logic [CW_W-1:0]   s1_cw_q,      s1_cw_d;
    logic              out_valid_q,  out_valid_d;
    logic [DATA_W-1:0] out_data_q,   out_data_d;
    logic [CW_W-1:0]   out_cw_q,     out_cw_d;
    logic [P-1:0]      out_syn_q,    out_syn_d;
    logic              out_single_q, out_single_d;
    logic              out_double_q, out_double_d;
    logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
    logic [CNT_W-1:0]  cnt_double_q, cnt_double_d;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic              w_adv;
    logic              w_out_hs;
    logic [CW_W-1:0]   w_enc_cw;
    logic [P-1:0]      w_syn;
    logic              w_par;
    logic [CW_W-1:0]   w_fix_cw;
    logic              w_single;
    logic              w_double;
    logic [DATA_W-1:0] w_dec_data;

    // Whole pipeline moves together; a stalled output freezes both stages.
    assign w_adv    = !out_valid_q || out_ready;
    assign w_out_hs = out_valid_q && out_ready;

    always_comb begin
        w_enc_cw = encode(in_data) ^ inj_mask;
    end

    // Decode of the stage-1 codeword. With q=1 the syndrome names the bad
    // position (0 meaning the overall parity bit itself). With q=0 and a
    // non-zero syndrome there is an even number of errors, so nothing is
    // flipped and the raw data is passed through.
    always_comb begin
        w_syn    = calc_syndrome(s1_cw_q);
        w_par    = ^s1_cw_q;
        w_fix_cw = s1_cw_q;
        if (w_par) begin
            w_fix_cw[w_syn] = ~s1_cw_q[w_syn];
        end
        w_single   = w_par;
        w_double   = !w_par && (w_syn != '0);
        w_dec_data = extract(w_fix_cw);
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_cw_d      = s1_cw_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_cw_d     = out_cw_q;
        out_syn_d    = out_syn_q;
        out_single_d = out_single_q;
        out_double_d = out_double_q;

        if (w_adv) begin
            // Valid bits always follow their source so bubbles propagate;
            // payload only loads with a real word to avoid needless toggling.
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            if (in_valid) begin
                s1_cw_d = w_enc_cw;
            end
            if (s1_valid_q) begin
                out_data_d   = w_dec_data;
                out_cw_d     = s1_cw_q;
                out_syn_d    = w_syn;
                out_single_d = w_single;
                out_double_d = w_double;
            end
        end
    end

    // Counters: clear beats increment; increments stop at all-ones.
    always_comb begin
        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;
        if (clr_cnt) begin
            cnt_single_d = '0;
            cnt_double_d = '0;
        end else if (w_out_hs) begin
            if (out_single_q && (cnt_single_q != CNT_MAX)) begin
                cnt_single_d = cnt_single_q + CNT_ONE;
            end
            if (out_double_q && (cnt_double_q != CNT_MAX)) begin
                cnt_double_d = cnt_double_q + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_cw_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_cw_q     <= '0;
            out_syn_q    <= '0;
            out_single_q <= 1'b0;
            out_double_q <= 1'b0;
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cw_q      <= s1_cw_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_cw_q     <= out_cw_d;
            out_syn_q    <= out_syn_d;
            out_single_q <= out_single_d;
            out_double_q <= out_double_d;
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready       = w_adv;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_cw         = out_cw_q;
    assign out_syndrome   = out_syn_q;
    assign out_err_single = out_single_q;
    assign out_err_double = out_double_q;
    assign cnt_single     = cnt_single_q;
    assign cnt_double     = cnt_double_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_secded_pipe
// Description : Scoreboard testbench for hamming_secded_pipe (DATA_W=4,
//               CNT_W=2). Expected results are hand-computed extended
//               Hamming(8,4) codewords pushed on acceptance and popped by a
//               monitor on each output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_secded_pipe;

    localparam int DW   = 4;
    localparam int PW   = 3;
    localparam int CW   = 8;
    localparam int CNTW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [CW-1:0]   inj_mask;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_cw;
    logic [PW-1:0]   out_syndrome;
    logic            out_err_single;
    logic            out_err_double;
    logic            clr_cnt;
    logic [CNTW-1:0] cnt_single;
    logic [CNTW-1:0] cnt_double;

    hamming_secded_pipe #(
        .DATA_W (DW),
        .CNT_W  (CNTW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .inj_mask       (inj_mask),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_cw         (out_cw),
        .out_syndrome   (out_syndrome),
        .out_err_single (out_err_single),
        .out_err_double (out_err_double),
        .clr_cnt        (clr_cnt),
        .cnt_single     (cnt_single),
        .cnt_double     (cnt_double)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] cw;
        logic [PW-1:0] s;
        logic          se;
        logic          de;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] snap_cw;
    logic [DW-1:0] snap_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] d, input logic [CW-1:0] cw,
                                input logic [PW-1:0] s, input logic se, input logic de);
        exp_t e;
        e.d  = d;
        e.cw = cw;
        e.s  = s;
        e.se = se;
        e.de = de;
        return e;
    endfunction

    // Monitor: every output handshake pops one expectation in order.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got cw %0h expected no output", out_cw);
            end else begin
                e = sb.pop_front();
                chk("out_data",       out_data,       e.d);
                chk("out_cw",         out_cw,         e.cw);
                chk("out_syndrome",   out_syndrome,   e.s);
                chk("out_err_single", out_err_single, e.se);
                chk("out_err_double", out_err_double, e.de);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] m, input exp_t e);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        inj_mask = m;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for the scoreboard to empty, then one more negedge so counters
    // reflect the last handshake.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_remaining", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        inj_mask = '0;
        out_ready = 1'b1;
        clr_cnt  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid",  out_valid,      0);
        chk("rst_out_data",   out_data,       0);
        chk("rst_out_cw",     out_cw,         0);
        chk("rst_syndrome",   out_syndrome,   0);
        chk("rst_flags",      {out_err_single, out_err_double}, 0);
        chk("rst_cnt_single", cnt_single,     0);
        chk("rst_cnt_double", cnt_double,     0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        sync();

        // Clean word, single error at position 5, double at positions 1,2
        send(4'b1011, 8'h00, mk(4'b1011, 8'hAA, 3'd0, 1'b0, 1'b0));
        drain();
        chk("cnt_single_clean", cnt_single, 0);
        chk("cnt_double_clean", cnt_double, 0);
        sync();
        send(4'b1011, 8'h20, mk(4'b1011, 8'h8A, 3'd5, 1'b1, 1'b0));
        drain();
        chk("cnt_single_inc", cnt_single, 1);
        sync();
        send(4'b1011, 8'h06, mk(4'b1011, 8'hAC, 3'd3, 1'b0, 1'b1));
        drain();
        chk("cnt_double_inc", cnt_double, 1);
        chk("cnt_single_hold", cnt_single, 1);
        sync();

        // Back-to-back stream: parity-bit error, data-bit corrections,
        // double error that changes extracted data, clean words.
        send(4'b1011, 8'h01, mk(4'b1011, 8'hAB, 3'd0, 1'b1, 1'b0));
        send(4'b0001, 8'h40, mk(4'b0001, 8'h4F, 3'd6, 1'b1, 1'b0));
        send(4'b1111, 8'h80, mk(4'b1111, 8'h7F, 3'd7, 1'b1, 1'b0));
        send(4'b0000, 8'h18, mk(4'b0001, 8'h18, 3'd7, 1'b0, 1'b1));
        send(4'b0000, 8'h00, mk(4'b0000, 8'h00, 3'd0, 1'b0, 1'b0));
        send(4'b1111, 8'h00, mk(4'b1111, 8'hFF, 3'd0, 1'b0, 1'b0));
        drain();
        chk("cnt_single_sat_stream", cnt_single, 3);
        chk("cnt_double_stream",     cnt_double, 2);
        sync();

        // Backpressure: stall the output for 3 cycles mid-stream
        fork
            begin
                send(4'd1, 8'h00, mk(4'd1, 8'h0F, 3'd0, 1'b0, 1'b0));
                send(4'd2, 8'h00, mk(4'd2, 8'h33, 3'd0, 1'b0, 1'b0));
                send(4'd3, 8'h00, mk(4'd3, 8'h3C, 3'd0, 1'b0, 1'b0));
                send(4'd4, 8'h00, mk(4'd4, 8'h55, 3'd0, 1'b0, 1'b0));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                snap_cw = out_cw;
                snap_d  = out_data;
                chk("stall_out_valid", out_valid, 1);
                chk("stall_in_ready",  in_ready,  0);
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_in_ready",  in_ready,  0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_cw_stable", out_cw,    snap_cw);
                    chk("stall_data_stable", out_data, snap_d);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        sync();

        // Clear
        clr_cnt = 1'b1;
        sync();
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_cnt_single", cnt_single, 0);
        chk("clr_cnt_double", cnt_double, 0);
        sync();

        // Saturation with 5 single errors
        repeat (5) send(4'b1011, 8'h20, mk(4'b1011, 8'h8A, 3'd5, 1'b1, 1'b0));
        drain();
        chk("cnt_single_sat5", cnt_single, 3);
        sync();

        // Clear coincident with a single-error handshake
        send(4'b1011, 8'h20, mk(4'b1011, 8'h8A, 3'd5, 1'b1, 1'b0));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk("clr_prio_wait_valid", out_valid, 1);
        clr_cnt = 1'b1;
        sync();
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_prio_cnt_single", cnt_single, 0);
        chk("clr_prio_cnt_double", cnt_double, 0);
        sync();

        // Reset mid-stream: in-flight word dropped, input during reset ignored
        send(4'd2, 8'h00, mk(4'd2, 8'h33, 3'd0, 1'b0, 1'b0));
        in_valid = 1'b1;
        in_data  = 4'd3;
        inj_mask = 8'h00;
        rst      = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        sync();
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_no_output", out_valid, 0);
        end
        sync();

        send(4'd4, 8'h00, mk(4'd4, 8'h55, 3'd0, 1'b0, 1'b0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
